vc_inject_arbiter: RTL and testbench

- Controller in front of the single-buffer virtual channel in each ring router. It shares the VC between two requesters: in-transit upstream ring traffic and local NI injection.
- Generates the VC input select, the flit mux and the push strobe. Holds the grant for a whole packet (wormhole lock, head to tail).
- Gives in-transit traffic priority, with a starvation bound for the NI. Blocks new injections when the ring is congested, so injection cannot deadlock the ring.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/vc_inject_arbiter_if.sv | 41 ++++
 rtl/flit_classify.sv | 28 ++
 rtl/vc_inject_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vc_inject_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: constants and types shared by the ring router, the VC buffer and
// the VC injection arbiter.
//   FLIT_W     flit width (48)
//   NODE_W     destination node-id width (2)
//   HEAD_MARK  head-flit marker found in flit[47:42]
//   TAIL_MARK  tail-flit marker found in flit[47:40]
//   arb_state_t  arbiter FSM state
//   arb_dbg_t    arbiter debug bundle (state plus the two head destinations)
package noc_pkg;

   localparam int FLIT_W = 48;
   localparam int NODE_W = 2;

   localparam logic [5:0] HEAD_MARK = 6'b101111;
   localparam logic [7:0] TAIL_MARK = 8'b11111111;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCK_UP = 2'd1,
      ST_LOCK_NI = 2'd2
   } arb_state_t;

   typedef struct packed {
      arb_state_t        state;
      logic [NODE_W-1:0] up_dest;
      logic [NODE_W-1:0] ni_dest;
   } arb_dbg_t;

endpackage

// File: rtl/vc_inject_arbiter_if.sv
// vc_inject_arbiter_if: flit handshakes between the two requesters, the
// arbiter and the VC buffer.
//   up_flit/up_valid/up_ready  upstream ring source
//   ni_flit/ni_valid/ni_ready  local NI source
//   inj_block                  congestion pause for new NI packets
//   buf_full                   VC buffer occupied
//   sel/vc_flit/vc_push        VC write side (sel: 1 = NI, 0 = upstream)
//
// Handshake: a flit moves on every cycle where its valid and ready are both
// high. ready is a zero-latency function of valid and the arbiter state, and
// valid must stay high with the flit stable until ready is seen. A ready
// without vc_push means the flit was discarded rather than written.
//
// master: the side that drives flits and the buffer status (router/bench).
// slave:  the arbiter.
interface vc_inject_arbiter_if;
   import noc_pkg::*;

   flit_t up_flit;
   logic  up_valid;
   logic  up_ready;
   flit_t ni_flit;
   logic  ni_valid;
   logic  ni_ready;
   logic  inj_block;
   logic  buf_full;
   logic  sel;
   flit_t vc_flit;
   logic  vc_push;

   modport master (
      output up_flit, up_valid, ni_flit, ni_valid, inj_block, buf_full,
      input  up_ready, ni_ready, sel, vc_flit, vc_push
   );

   modport slave (
      input  up_flit, up_valid, ni_flit, ni_valid, inj_block, buf_full,
      output up_ready, ni_ready, sel, vc_flit, vc_push
   );

endinterface

// File: rtl/flit_classify.sv
// flit_classify: combinational decode of a flit's header byte.
//   flit     in  48  flit to classify
//   is_head  out 1   head marker present (and not a tail)
//   is_tail  out 1   tail marker present
//   dest     out 2   destination node field flit[41:40]
module flit_classify
   import noc_pkg::*;
#(
   parameter logic [5:0] HEAD = HEAD_MARK,
   parameter logic [7:0] TAIL = TAIL_MARK
) (
   input  flit_t             flit,
   output logic              is_head,
   output logic              is_tail,
   output logic [NODE_W-1:0] dest
);

   // Payload bits carry no routing information.
   logic unused_payload;
   assign unused_payload = ^flit[39:0];

   // The full-byte tail marker overlaps the head marker field, so a flit
   // matching both is a tail.
   assign is_tail = (flit[47:40] == TAIL);
   assign is_head = (flit[47:42] == HEAD) & ~is_tail;
   assign dest    = flit[41:40];

endmodule

// File: rtl/vc_inject_arbiter.sv
// vc_inject_arbiter: shares one single-buffer VC between in-transit upstream
// ring traffic and local NI injection. The grant is held from head to tail.
// Upstream traffic has priority; the NI is guaranteed a turn after
// STARVE_MAX upstream packets pass it. New NI packets are held off while
// inj_block is high.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   bus          slave modport: both sources, congestion/full inputs, VC side
//   lock_ni      out  an NI packet holds the VC
//   lock_up      out  an upstream packet holds the VC
//   starve_cnt   out  upstream packets that passed a waiting NI head
//   stall_alarm  out  lock idle for LOCK_TIMEOUT cycles
//   err_proto    out  sticky protocol-error flag
//   dbg          out  FSM state and head destinations
module vc_inject_arbiter
   import noc_pkg::*;
#(
   parameter logic [5:0] HEAD         = HEAD_MARK,
   parameter logic [7:0] TAIL         = TAIL_MARK,
   parameter int         STARVE_MAX   = 4,
   parameter int         LOCK_TIMEOUT = 64,
   parameter int         CNT_W        = 7
) (
   input  logic                clk,
   input  logic                rst,
   vc_inject_arbiter_if.slave  bus,
   output logic                lock_ni,
   output logic                lock_up,
   output logic [2:0]          starve_cnt,
   output logic                stall_alarm,
   output logic                err_proto,
   output arb_dbg_t            dbg
);

   arb_state_t        state_q, state_d;
   logic [2:0]        starve_q, starve_d;
   logic [CNT_W-1:0]  idle_q, idle_d;
   logic              err_q, err_d;

   logic              up_head, up_tail, ni_head, ni_tail;
   logic [NODE_W-1:0] up_dest, ni_dest;
   logic              up_hv, ni_hv;
   logic              ni_wins, up_wins;
   logic              grant_up, grant_ni, drop_up, drop_ni, sel_c;
   logic              acc_up, acc_ni, acc_any, acc_head, acc_tail;

   flit_classify #(.HEAD(HEAD), .TAIL(TAIL)) u_up_cls (
      .flit    (bus.up_flit),
      .is_head (up_head),
      .is_tail (up_tail),
      .dest    (up_dest)
   );

   flit_classify #(.HEAD(HEAD), .TAIL(TAIL)) u_ni_cls (
      .flit    (bus.ni_flit),
      .is_head (ni_head),
      .is_tail (ni_tail),
      .dest    (ni_dest)
   );

   assign up_hv = bus.up_valid & up_head;
   assign ni_hv = bus.ni_valid & ni_head;

   // The NI only jumps ahead of a waiting upstream head once the starvation
   // count has reached its bound; congestion always holds it back.
   assign ni_wins = ni_hv & ~bus.inj_block &
                    ((starve_q == 3'(STARVE_MAX)) | ~up_hv);
   assign up_wins = up_hv & ~ni_wins;

   // Grant, mux select and discard decisions.
   always_comb begin
      grant_up = 1'b0;
      grant_ni = 1'b0;
      drop_up  = 1'b0;
      drop_ni  = 1'b0;
      sel_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant_up = up_wins;
            grant_ni = ni_wins;
            sel_c    = ni_wins;
            // A stray body/tail with nobody else taking the VC is discarded
            // so it cannot wedge its source. A flit whose source is blocked
            // or beaten by the other head simply waits.
            drop_up  = bus.up_valid & ~up_head & ~ni_wins;
            drop_ni  = bus.ni_valid & ~ni_head & ~up_wins & ~bus.inj_block &
                       ~drop_up;
         end
         ST_LOCK_UP: grant_up = 1'b1;
         ST_LOCK_NI: begin
            grant_ni = 1'b1;
            sel_c    = 1'b1;
         end
         default: ;
      endcase
   end

   // While rst is low every strobe is forced off, independent of the clock.
   assign acc_up   = rst & grant_up & bus.up_valid & ~bus.buf_full;
   assign acc_ni   = rst & grant_ni & bus.ni_valid & ~bus.buf_full;
   assign acc_any  = acc_up | acc_ni;
   assign acc_head = (acc_up & up_head) | (acc_ni & ni_head);
   assign acc_tail = (acc_up & up_tail) | (acc_ni & ni_tail);

   assign bus.up_ready = acc_up | (rst & drop_up);
   assign bus.ni_ready = acc_ni | (rst & drop_ni);
   assign bus.vc_push  = acc_any;
   assign bus.sel      = rst & sel_c;
   assign bus.vc_flit  = bus.sel ? bus.ni_flit : bus.up_flit;

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      idle_d   = idle_q;
      err_d    = err_q | (rst & (drop_up | drop_ni));
      case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (acc_ni) begin
               state_d  = ST_LOCK_NI;
               starve_d = '0;
            end else if (acc_up) begin
               state_d = ST_LOCK_UP;
            end
         end
         ST_LOCK_UP, ST_LOCK_NI: begin
            if (acc_any) begin
               idle_d = '0;
            end else if (idle_q != '1) begin
               idle_d = idle_q + CNT_W'(1);
            end
            // A head inside a packet is passed on as body but flagged.
            if (acc_head) begin
               err_d = 1'b1;
            end
            if (acc_tail) begin
               state_d = ST_IDLE;
               idle_d  = '0;
            end
            if ((state_q == ST_LOCK_UP) && acc_tail && ni_hv &&
                (starve_q < 3'(STARVE_MAX))) begin
               starve_d = starve_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idle_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         idle_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         idle_q   <= idle_d;
         err_q    <= err_d;
      end
   end

   assign lock_up     = (state_q == ST_LOCK_UP);
   assign lock_ni     = (state_q == ST_LOCK_NI);
   assign starve_cnt  = starve_q;
   assign stall_alarm = (state_q != ST_IDLE) &&
                        (idle_q >= CNT_W'(LOCK_TIMEOUT));
   assign err_proto   = err_q;

   assign dbg.state   = state_q;
   assign dbg.up_dest = up_dest;
   assign dbg.ni_dest = ni_dest;

endmodule

// File: tb/tb_vc_inject_arbiter.sv
// tb_vc_inject_arbiter: self-checking bench for vc_inject_arbiter. Every
// flit expected on the VC is queued when it is driven; a negedge monitor
// pops and compares {sel, vc_flit} on each vc_push.
module tb_vc_inject_arbiter;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        lock_ni, lock_up;
   logic [2:0]  starve_cnt;
   logic        stall_alarm, err_proto;
   arb_dbg_t    dbg;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [48:0] exp_q[$];

   vc_inject_arbiter_if bus ();

   vc_inject_arbiter #(
      .STARVE_MAX   (4),
      .LOCK_TIMEOUT (64),
      .CNT_W        (7)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .lock_ni     (lock_ni),
      .lock_up     (lock_up),
      .starve_cnt  (starve_cnt),
      .stall_alarm (stall_alarm),
      .err_proto   (err_proto),
      .dbg         (dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every push must match the oldest expected flit.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.vc_push === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("push_with_empty_queue", 64'(bus.vc_push), 64'(0));
         end else begin
            logic [48:0] e;
            e = exp_q.pop_front();
            check("push_flit", 64'({bus.sel, bus.vc_flit}), 64'(e));
         end
      end
   end

   // ---------------- flit builders ----------------
   function automatic flit_t head_flit(input logic [1:0] dest);
      return {HEAD_MARK, dest, 8'($urandom), 32'($urandom)};
   endfunction

   function automatic flit_t tail_flit();
      return {TAIL_MARK, 8'($urandom), 32'($urandom)};
   endfunction

   // Top byte kept below 0xB0 so it is never a head or tail.
   function automatic flit_t body_flit();
      return {8'($urandom_range(0, 175)), 8'($urandom), 32'($urandom)};
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one flit from a source, queue its expected push, wait (bounded)
   // for ready, then drop valid after the accepting edge.
   task automatic xfer(input bit from_ni, input flit_t f, output int waits);
      logic rdy;
      waits = 0;
      if (from_ni) begin
         bus.ni_flit  = f;
         bus.ni_valid = 1'b1;
      end else begin
         bus.up_flit  = f;
         bus.up_valid = 1'b1;
      end
      exp_q.push_back({from_ni, f});
      #1;
      rdy = from_ni ? bus.ni_ready : bus.up_ready;
      while (!rdy && waits < 300) begin
         @(posedge clk);
         #2;
         waits++;
         rdy = from_ni ? bus.ni_ready : bus.up_ready;
      end
      check(from_ni ? "ni_accept" : "up_accept", 64'(rdy), 64'(1));
      @(posedge clk);
      #1;
      if (from_ni) bus.ni_valid = 1'b0;
      else         bus.up_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      flit_t f, nh, uh;
      int    w;

      rst           = 1'b0;
      bus.up_flit   = body_flit();
      bus.up_valid  = 1'b0;
      bus.ni_flit   = head_flit(2'd1);
      bus.ni_valid  = 1'b0;
      bus.inj_block = 1'b0;
      bus.buf_full  = 1'b0;
      f             = bus.up_flit;

      // Reset values.
      #3;
      check("rst_state",   64'(dbg.state),    64'(ST_IDLE));
      check("rst_sel",     64'(bus.sel),      64'(0));
      check("rst_push",    64'(bus.vc_push),  64'(0));
      check("rst_up_rdy",  64'(bus.up_ready), 64'(0));
      check("rst_ni_rdy",  64'(bus.ni_ready), 64'(0));
      check("rst_vc_flit", 64'(bus.vc_flit),  64'(f));
      check("rst_starve",  64'(starve_cnt),   64'(0));
      check("rst_alarm",   64'(stall_alarm),  64'(0));
      check("rst_err",     64'(err_proto),    64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      // 1: upstream head 0xBC.., two bodies, tail; one push per cycle.
      f = {8'hBC, 8'($urandom), 32'($urandom)};
      xfer(1'b0, f, w);
      check("t1_head_wait", 64'(w), 64'(0));
      check("t1_lock_up", 64'(lock_up), 64'(1));
      for (int i = 0; i < 2; i++) begin
         xfer(1'b0, body_flit(), w);
         check("t1_body_wait", 64'(w), 64'(0));
      end
      xfer(1'b0, tail_flit(), w);
      check("t1_tail_wait", 64'(w), 64'(0));
      check("t1_idle", 64'(dbg.state), 64'(ST_IDLE));
      check("t1_starve", 64'(starve_cnt), 64'(0));

      // 2: NI head waits while four upstream packets pass, then wins.
      nh = head_flit(2'd2);
      bus.ni_flit  = nh;
      bus.ni_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         xfer(1'b0, head_flit(2'($urandom)), w);
         check("t2_up_head_wait", 64'(w), 64'(0));
         xfer(1'b0, tail_flit(), w);
         check("t2_starve", 64'(starve_cnt), 64'(k));
      end
      uh = head_flit(2'd3);
      bus.up_flit  = uh;
      bus.up_valid = 1'b1;
      xfer(1'b1, nh, w);
      check("t2_ni_head_wait", 64'(w), 64'(0));
      check("t2_lock_ni", 64'(lock_ni), 64'(1));
      check("t2_starve_clr", 64'(starve_cnt), 64'(0));
      xfer(1'b1, tail_flit(), w);
      xfer(1'b0, uh, w);
      check("t2_up_after_ni", 64'(w), 64'(0));
      xfer(1'b0, tail_flit(), w);

      // 3: inj_block holds a lone NI head off, but not a packet in flight.
      bus.ni_flit   = head_flit(2'd0);
      bus.ni_valid  = 1'b1;
      bus.inj_block = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("t3_blocked_rdy", 64'(bus.ni_ready), 64'(0));
         tick();
      end
      bus.inj_block = 1'b0;
      xfer(1'b1, bus.ni_flit, w);
      check("t3_unblock_wait", 64'(w), 64'(0));
      bus.inj_block = 1'b1;
      xfer(1'b1, body_flit(), w);
      check("t3_body_wait", 64'(w), 64'(0));
      xfer(1'b1, tail_flit(), w);
      check("t3_tail_wait", 64'(w), 64'(0));
      bus.inj_block = 1'b0;

      // 4: buffer full inside LOCK_NI; alarm after 64 idle cycles.
      xfer(1'b1, head_flit(2'd1), w);
      f = body_flit();
      bus.buf_full = 1'b1;
      bus.ni_flit  = f;
      bus.ni_valid = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         #1;
         if (k == 1 || k == 64 || k == 65 || k == 70) begin
            check($sformatf("t4_alarm_c%0d", k), 64'(stall_alarm),
                  64'(k >= 65));
            check("t4_full_rdy", 64'(bus.ni_ready), 64'(0));
         end
         tick();
      end
      bus.buf_full = 1'b0;
      exp_q.push_back({1'b1, f});
      #1;
      check("t4_release_rdy", 64'(bus.ni_ready), 64'(1));
      check("t4_alarm_hold", 64'(stall_alarm), 64'(1));
      tick();
      bus.ni_valid = 1'b0;
      check("t4_alarm_clr", 64'(stall_alarm), 64'(0));
      xfer(1'b1, tail_flit(), w);

      // 5: stray upstream body while idle is discarded and flagged.
      bus.up_flit  = body_flit();
      bus.up_valid = 1'b1;
      #1;
      check("t5_drop_rdy", 64'(bus.up_ready), 64'(1));
      check("t5_drop_push", 64'(bus.vc_push), 64'(0));
      tick();
      bus.up_valid = 1'b0;
      check("t5_err_set", 64'(err_proto), 64'(1));
      repeat (5) tick();
      check("t5_err_sticky", 64'(err_proto), 64'(1));

      // 6: asynchronous reset in the middle of an upstream packet.
      xfer(1'b0, head_flit(2'd2), w);
      f = body_flit();
      bus.up_flit  = f;
      bus.up_valid = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("t6_state",   64'(dbg.state),    64'(ST_IDLE));
      check("t6_up_rdy",  64'(bus.up_ready), 64'(0));
      check("t6_push",    64'(bus.vc_push),  64'(0));
      check("t6_sel",     64'(bus.sel),      64'(0));
      check("t6_vc_flit", 64'(bus.vc_flit),  64'(f));
      check("t6_err",     64'(err_proto),    64'(0));
      check("t6_lock_up", 64'(lock_up),      64'(0));
      repeat (2) @(posedge clk);
      #1;
      bus.up_valid = 1'b0;
      rst = 1'b1;
      xfer(1'b1, head_flit(2'd3), w);
      check("t6_ni_head_wait", 64'(w), 64'(0));
      check("t6_lock_ni", 64'(lock_ni), 64'(1));
      xfer(1'b1, tail_flit(), w);

      repeat (3) tick();
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
